// File: rtl/mutative_reconfig_ctrl.sv
// ---------------------------------------------------------------------------
// mutative_reconfig_ctrl
//
// Sequences a run-time associativity change for the mutative cache. A mode
// request first stalls new upstream accesses and waits for the in-flight
// access to drain. The controller then walks every line (way-minor order),
// writes back dirty valid lines and invalidates them. Only after that does it
// switch `setup`, the mode consumed by the comparator and array-enable logic.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   cfg_req, cfg_mode      level request (held until cfg_ack) and target mode
//   cfg_ack                one-cycle pulse: new setup is in effect
//   setup                  current mode (0=DM, 1=2-way, 2=4-way, 3=8-way)
//   ufp_busy               main cache FSM has an access in flight
//   stall                  block acceptance of new upstream accesses
//   walk_set, walk_way     maintenance access address
//   walk_csb, walk_web     active-low array select / write enable
//                          (a walk write clears valid and dirty)
//   line_valid, line_dirty status of the walked line, one cycle after the read
//   wb_req, wb_ack         write back line {walk_set, walk_way}, held until ack
// ---------------------------------------------------------------------------
module mutative_reconfig_ctrl #(
    parameter int WAYS         = 8,
    parameter int SETS         = 16,
    parameter int WAY_IDX_BITS = 3,
    parameter int SET_IDX_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_req,
    input  logic [1:0]              cfg_mode,
    output logic                    cfg_ack,
    output logic [1:0]              setup,
    input  logic                    ufp_busy,
    output logic                    stall,
    output logic [SET_IDX_BITS-1:0] walk_set,
    output logic [WAY_IDX_BITS-1:0] walk_way,
    output logic                    walk_csb,
    output logic                    walk_web,
    input  logic                    line_valid,
    input  logic                    line_dirty,
    output logic                    wb_req,
    input  logic                    wb_ack
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_READ   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_WB     = 3'd4,
        ST_INV    = 3'd5,
        ST_SWITCH = 3'd6,
        ST_ACK    = 3'd7
    } state_t;

    localparam logic [SET_IDX_BITS-1:0] SET_ZERO = {SET_IDX_BITS{1'b0}};
    localparam logic [WAY_IDX_BITS-1:0] WAY_ZERO = {WAY_IDX_BITS{1'b0}};
    localparam logic [SET_IDX_BITS-1:0] SET_ONE  = {{(SET_IDX_BITS-1){1'b0}}, 1'b1};
    localparam logic [WAY_IDX_BITS-1:0] WAY_ONE  = {{(WAY_IDX_BITS-1){1'b0}}, 1'b1};
    localparam logic [SET_IDX_BITS-1:0] LAST_SET = SET_IDX_BITS'(SETS - 1);
    localparam logic [WAY_IDX_BITS-1:0] LAST_WAY = WAY_IDX_BITS'(WAYS - 1);

    state_t                  state_r;
    state_t                  state_s;
    logic [1:0]              target_r;
    logic [1:0]              target_s;
    logic [1:0]              setup_r;
    logic [1:0]              setup_s;
    logic [SET_IDX_BITS-1:0] walk_set_r;
    logic [SET_IDX_BITS-1:0] walk_set_s;
    logic [WAY_IDX_BITS-1:0] walk_way_r;
    logic [WAY_IDX_BITS-1:0] walk_way_s;
    logic [SET_IDX_BITS-1:0] adv_set_s;
    logic [WAY_IDX_BITS-1:0] adv_way_s;
    logic                    last_line_s;

    logic cfg_ack_r;
    logic stall_r;
    logic walk_csb_r;
    logic walk_web_r;
    logic wb_req_r;
    logic cfg_ack_s;
    logic stall_s;
    logic walk_csb_s;
    logic walk_web_s;
    logic wb_req_s;

    // Next walk address in way-minor order; the walk never wraps past the last line.
    always_comb begin
        adv_set_s   = walk_set_r;
        adv_way_s   = walk_way_r;
        last_line_s = (walk_set_r == LAST_SET) && (walk_way_r == LAST_WAY);
        if (walk_way_r == LAST_WAY) begin
            adv_way_s = WAY_ZERO;
            adv_set_s = walk_set_r + SET_ONE;
        end else begin
            adv_way_s = walk_way_r + WAY_ONE;
        end
    end

    // Next-state, target latch, walk counters and mode switch.
    always_comb begin
        state_s    = state_r;
        target_s   = target_r;
        setup_s    = setup_r;
        walk_set_s = walk_set_r;
        walk_way_s = walk_way_r;
        case (state_r)
            ST_IDLE: begin
                if (cfg_req) begin
                    target_s = cfg_mode;
                    // Same mode needs no flush: acknowledge without stalling.
                    if (cfg_mode == setup_r) begin
                        state_s = ST_ACK;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!ufp_busy) begin
                    walk_set_s = SET_ZERO;
                    walk_way_s = WAY_ZERO;
                    state_s    = ST_READ;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_READ: begin
                state_s = ST_CHECK;
            end
            ST_CHECK: begin
                if (!line_valid) begin
                    if (last_line_s) begin
                        state_s = ST_SWITCH;
                    end else begin
                        walk_set_s = adv_set_s;
                        walk_way_s = adv_way_s;
                        state_s    = ST_READ;
                    end
                end else if (line_dirty) begin
                    state_s = ST_WB;
                end else begin
                    state_s = ST_INV;
                end
            end
            ST_WB: begin
                if (wb_ack) begin
                    state_s = ST_INV;
                end else begin
                    state_s = ST_WB;
                end
            end
            ST_INV: begin
                if (last_line_s) begin
                    state_s = ST_SWITCH;
                end else begin
                    walk_set_s = adv_set_s;
                    walk_way_s = adv_way_s;
                    state_s    = ST_READ;
                end
            end
            ST_SWITCH: begin
                setup_s = target_r;
                state_s = ST_ACK;
            end
            ST_ACK: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output comes straight off a flop.
    always_comb begin
        walk_csb_s = !((state_s == ST_READ) || (state_s == ST_INV));
        walk_web_s = (state_s != ST_INV);
        wb_req_s   = (state_s == ST_WB);
        cfg_ack_s  = (state_s == ST_ACK);
        // A same-mode acknowledge (IDLE straight to ACK) never stalls.
        stall_s    = (state_s != ST_IDLE) &&
                     !((state_s == ST_ACK) && (state_r == ST_IDLE));
    end

    // State, mode and walk-address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            target_r   <= 2'd3;
            setup_r    <= 2'd3;
            walk_set_r <= SET_ZERO;
            walk_way_r <= WAY_ZERO;
        end else begin
            state_r    <= state_s;
            target_r   <= target_s;
            setup_r    <= setup_s;
            walk_set_r <= walk_set_s;
            walk_way_r <= walk_way_s;
        end
    end

    // Registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ack_r  <= 1'b0;
            stall_r    <= 1'b0;
            walk_csb_r <= 1'b1;
            walk_web_r <= 1'b1;
            wb_req_r   <= 1'b0;
        end else begin
            cfg_ack_r  <= cfg_ack_s;
            stall_r    <= stall_s;
            walk_csb_r <= walk_csb_s;
            walk_web_r <= walk_web_s;
            wb_req_r   <= wb_req_s;
        end
    end

    assign cfg_ack  = cfg_ack_r;
    assign setup    = setup_r;
    assign stall    = stall_r;
    assign walk_set = walk_set_r;
    assign walk_way = walk_way_r;
    assign walk_csb = walk_csb_r;
    assign walk_web = walk_web_r;
    assign wb_req   = wb_req_r;

endmodule

// File: tb/tb_mutative_reconfig_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for mutative_reconfig_ctrl. A tag-array model answers walk reads
// and applies walk writes; a writeback responder acks after a chosen delay.
// For every request the reference model derives, from the array contents and
// the requested mode, the ordered list of accesses, writebacks, the final
// acknowledge and its latency, and pushes them into a scoreboard queue. A
// separate monitor pops and compares whenever the DUT presents an event.
// ---------------------------------------------------------------------------
module tb_mutative_reconfig_ctrl;

    localparam int SETS = 16;
    localparam int WAYS = 8;

    localparam int EV_RD  = 0;
    localparam int EV_WR  = 1;
    localparam int EV_WB  = 2;
    localparam int EV_ACK = 3;

    typedef struct {
        int kind;
        int s;
        int w;
        int v;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_req;
    logic [1:0] cfg_mode;
    logic       cfg_ack;
    logic [1:0] setup;
    logic       ufp_busy;
    logic       stall;
    logic [3:0] walk_set;
    logic [2:0] walk_way;
    logic       walk_csb;
    logic       walk_web;
    logic       line_valid;
    logic       line_dirty;
    logic       wb_req;
    logic       wb_ack;

    mutative_reconfig_ctrl #(
        .WAYS(8), .SETS(16), .WAY_IDX_BITS(3), .SET_IDX_BITS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_req(cfg_req), .cfg_mode(cfg_mode), .cfg_ack(cfg_ack), .setup(setup),
        .ufp_busy(ufp_busy), .stall(stall),
        .walk_set(walk_set), .walk_way(walk_way), .walk_csb(walk_csb), .walk_web(walk_web),
        .line_valid(line_valid), .line_dirty(line_dirty),
        .wb_req(wb_req), .wb_ack(wb_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    bit  arr_v [SETS][WAYS];
    bit  arr_d [SETS][WAYS];
    ev_t q[$];

    int model_setup = 3;
    int exp_mode;
    int exp_lat;
    int exp_first_rd;
    int exp_stall_op;
    int acc_cyc;
    int rd_count;
    int first_rd_rel;
    bit op_active = 1'b0;
    bit done = 1'b0;
    int wb_wait = 1;
    int wb_cnt = 0;
    bit hold = 1'b0;
    bit wb_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pop_cmp(input int kind, input int s, input int w, input int v);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected actual kind=%0d set=%0d way=%0d val=%0d required nothing",
                     kind, s, w, v);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.s != s || e.w != w || e.v != v) begin
                errors++;
                $display("FAIL sb_event actual kind=%0d set=%0d way=%0d val=%0d required kind=%0d set=%0d way=%0d val=%0d",
                         kind, s, w, v, e.kind, e.s, e.w, e.v);
            end
        end
    endtask

    function automatic int count_valid();
        int n = 0;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                if (arr_v[s][w]) n++;
        return n;
    endfunction

    task automatic fill(input int pct);
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                arr_v[s][w] = ($urandom_range(0, 99) < pct);
                arr_d[s][w] = arr_v[s][w] && ($urandom_range(0, 1) == 1);
            end
    endtask

    // Responders (array, writeback) and scoreboard monitor, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (wb_req) begin
                wb_cnt++;
                wb_ack = (wb_cnt == wb_wait);
            end else begin
                wb_cnt = 0;
                wb_ack = ($urandom_range(0, 5) == 0);
            end
            if (!walk_csb && walk_web) begin
                line_valid = arr_v[walk_set][walk_way];
                line_dirty = arr_d[walk_set][walk_way];
                hold = 1'b1;
            end else if (hold) begin
                hold = 1'b0;
            end else begin
                line_valid = 1'($urandom_range(0, 1));
                line_dirty = 1'($urandom_range(0, 1));
            end
            if (!walk_csb && !walk_web) begin
                arr_v[walk_set][walk_way] = 1'b0;
                arr_d[walk_set][walk_way] = 1'b0;
            end
            if (!rst_n) begin
                wb_prev = 1'b0;
            end else if (op_active) begin
                chk("stall_in_op", stall, exp_stall_op);
                if (!walk_csb) begin
                    if (walk_web) begin
                        rd_count++;
                        if (rd_count == 1) first_rd_rel = cyc - acc_cyc;
                        pop_cmp(EV_RD, walk_set, walk_way, 0);
                    end else begin
                        pop_cmp(EV_WR, walk_set, walk_way, 0);
                    end
                end
                if (wb_req && !wb_prev) pop_cmp(EV_WB, walk_set, walk_way, 0);
                if (cfg_ack) begin
                    pop_cmp(EV_ACK, 0, 0, setup);
                    chk("ack_latency", cyc - acc_cyc, exp_lat);
                    chk("sb_drained", q.size(), 0);
                    if (exp_stall_op == 1) begin
                        chk("first_read_cycle", first_rd_rel, exp_first_rd);
                        chk("read_count", rd_count, SETS * WAYS);
                    end
                    op_active = 1'b0;
                    done = 1'b1;
                end else begin
                    chk("setup_hold", setup, model_setup);
                end
            end else begin
                chk("idle_stall", stall, 0);
                chk("idle_ack", cfg_ack, 0);
                chk("idle_csb", walk_csb, 1);
                chk("idle_wbreq", wb_req, 0);
                chk("idle_setup", setup, model_setup);
            end
            wb_prev = wb_req;
        end
    end

    // Reference model: expected event list and latency from the array contents.
    task automatic start_op(input int mode, input int b, input int wbw);
        int lines;
        @(negedge clk);
        #1;
        wb_wait = wbw;
        q.delete();
        if (mode == model_setup) begin
            q.push_back('{EV_ACK, 0, 0, mode});
            exp_lat = 1;
            exp_stall_op = 0;
            exp_first_rd = 0;
        end else begin
            lines = 0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    q.push_back('{EV_RD, s, w, 0});
                    if (arr_v[s][w]) begin
                        if (arr_d[s][w]) begin
                            q.push_back('{EV_WB, s, w, 0});
                            lines += 3 + wbw;
                        end else begin
                            lines += 3;
                        end
                        q.push_back('{EV_WR, s, w, 0});
                    end else begin
                        lines += 2;
                    end
                end
            q.push_back('{EV_ACK, 0, 0, mode});
            exp_lat = b + 1 + lines + 2;
            exp_first_rd = b + 2;
            exp_stall_op = 1;
        end
        exp_mode = mode;
        acc_cyc = cyc;
        rd_count = 0;
        first_rd_rel = -1;
        done = 1'b0;
        op_active = 1'b1;
        cfg_mode = 2'(mode);
        cfg_req = 1'b1;
        ufp_busy = (b > 0);
    endtask

    task automatic finish_op(input int b, input int chg_c, input int chg_mode);
        int c = 0;
        while (!done && c < 3000) begin
            @(negedge clk);
            #1;
            c++;
            ufp_busy = (c <= b);
            if (c == chg_c) cfg_mode = 2'(chg_mode);
        end
        cfg_req = 1'b0;
        ufp_busy = 1'b0;
        chk("ack_seen", done, 1);
        if (done) begin
            model_setup = exp_mode;
            if (exp_stall_op == 1) chk("array_clean", count_valid(), 0);
        end else begin
            op_active = 1'b0;
            q.delete();
        end
    endtask

    task automatic run_op(input int mode, input int b, input int wbw, input int chg_c, input int chg_mode);
        start_op(mode, b, wbw);
        finish_op(b, chg_c, chg_mode);
    endtask

    initial begin
        int c;
        cfg_req = 1'b0;
        cfg_mode = 2'd0;
        ufp_busy = 1'b0;
        wb_ack = 1'b0;
        line_valid = 1'b0;
        line_dirty = 1'b0;
        fill(0);

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        chk("rst_setup", setup, 3);
        chk("rst_stall", stall, 0);
        chk("rst_ack", cfg_ack, 0);
        chk("rst_wbreq", wb_req, 0);
        chk("rst_csb", walk_csb, 1);
        chk("rst_web", walk_web, 1);
        chk("rst_set", walk_set, 0);
        chk("rst_way", walk_way, 0);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Same mode: immediate ack, no stall, no walk.
        run_op(3, 0, 1, 0, 0);
        // All lines invalid, 3 -> 0.
        fill(0);
        run_op(0, 0, 1, 0, 0);
        // Single dirty line at set 5 way 2, writeback acked after a delay.
        fill(0);
        arr_v[5][2] = 1'b1;
        arr_d[5][2] = 1'b1;
        run_op(2, 0, 5, 0, 0);
        // Request mode changes mid-walk: accepted mode 1 must stick.
        fill(30);
        run_op(1, 0, 2, 40, 2);
        // Drain: upstream busy for 10 cycles at request.
        fill(50);
        run_op(3, 10, 2, 0, 0);

        // Reset in the middle of a writeback at set 3.
        fill(0);
        arr_v[1][4] = 1'b1;
        arr_d[1][4] = 1'b1;
        arr_v[3][0] = 1'b1;
        arr_d[3][0] = 1'b1;
        arr_v[3][1] = 1'b1;
        start_op(1, 0, 40);
        c = 0;
        while (!(wb_req && walk_set == 4'd3) && c < 3000) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk("rst_reached_wb_set3", int'(wb_req && walk_set == 4'd3), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_setup", setup, 3);
        chk("midrst_wbreq", wb_req, 0);
        chk("midrst_stall", stall, 0);
        chk("midrst_csb", walk_csb, 1);
        cfg_req = 1'b0;
        op_active = 1'b0;
        q.delete();
        model_setup = 3;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        // Fresh request walks again from set 0 way 0.
        run_op(0, 0, 2, 0, 0);

        // Randomized requests.
        for (int i = 0; i < 8; i++) begin
            case (i % 4)
                0: fill(0);
                1: fill(10);
                2: fill(50);
                default: fill(100);
            endcase
            run_op($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(1, 4),
                   $urandom_range(1, 40), $urandom_range(0, 3));
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
